i2c_slave: RTL and testbench
============================

# i2c_slave

Clocked I2C target (slave) that answers the bus driven by the team's `i2c_master`. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, and moves data bytes between the bus and two byte-wide FIFO ports. Received bytes go out on a write strobe; transmitted bytes come in on a read strobe. It serves as both the bench counterpart of `i2c_master` and a reusable target front-end.

## Interface
Parameters:
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target answers to.

Ports:
- `clk`  in  1  system clock; must run at ≥ 8× SCL frequency.
- `i2c_reset_n`  in  1  reset; asynchronous assert, active-low.
- `scl_in`  in  1  raw SCL level (asynchronous).
- `sda_in`  in  1  raw SDA level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. Open-drain buffer is external.
- `tx_data`  in  8  next byte to send; show-ahead, valid while `tx_empty`=0.
- `tx_empty`  in  1  TX source empty.
- `fifo_tx_rd_en`  out  1  one-cycle pulse; `tx_data` consumed in that cycle.
- `rx_data`  out  8  last received data byte.
- `rx_full`  in  1  RX sink full.
- `fifo_rx_wr_en`  out  1  one-cycle pulse; `rx_data` valid in that cycle.
- `busy`  out  1  1 while this target is addressed (ADDR_ACK through end of transfer).
- `slave_rw`  out  1  R/W bit of the current addressed transfer.
- `tx_underrun`  out  1  one-cycle pulse when a byte is loaded while `tx_empty`=1.

## Operation
- Input conditioning: 2-FF synchronizer on `scl_in`/`sda_in`, plus one history register.
  - SCL rise/fall = change of synchronized SCL.
  - START = synced SDA 1→0 while SCL=1.
  - STOP = synced SDA 0→1 while SCL=1.
- SDA sampling and driving:
  - Bits are sampled on SCL rise.
  - `sda_oe` changes only on SCL fall, except at START/STOP, where it is released immediately.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP. A 3-bit bit counter counts MSB first.
- START in any state → ADDR, counter cleared, `sda_oe`=0. This covers repeated START.
- STOP in any state → IDLE, `sda_oe`=0, `busy`=0.
- ADDR: shift 8 bits.
  - On the 8th rise, if [7:1]==SLAVE_ADDR: latch `slave_rw`, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP and never drive SDA.
- ADDR_ACK:
  - Drive `sda_oe`=1 from the next SCL fall until the following fall. `busy`=1.
  - At the releasing fall, if rw=0 → RX_BYTE.
  - If rw=1: pulse `fifo_tx_rd_en`, load shift register, drive MSB (`sda_oe` = ~bit), → TX_BYTE.
- RX_BYTE: on the 8th rise, capture the byte.
  - If `rx_full`=0: update `rx_data` and pulse `fifo_rx_wr_en` (one cycle), then ACK.
  - If `rx_full`=1: no write; NACK (`sda_oe` stays 0 through the ack clock).
  - → RX_ACK. At the end of the ack clock → RX_BYTE.
- TX_BYTE: shift out on each SCL fall. After the 8th bit's fall, release SDA → TX_ACK.
- TX_ACK: sample SDA on rise.
  - 0 (ACK): at the next fall, load the next byte as in ADDR_ACK → TX_BYTE.
  - 1 (NACK): → WAIT_STOP.
- TX load with `tx_empty`=1: still pulse `fifo_tx_rd_en`; send 8'hFF instead; pulse `tx_underrun`.
- WAIT_STOP: idle, SDA released, until STOP or START.

## Timing
- Reset values: `sda_oe`=0, `fifo_tx_rd_en`=0, `fifo_rx_wr_en`=0, `rx_data`=8'h00, `busy`=0, `slave_rw`=0, `tx_underrun`=0. State = IDLE.
- Detection latency: 3 clk from a raw pin edge to the internal edge/START/STOP event.
- `sda_oe` update: 1 clk after a detected SCL fall.
- `fifo_rx_wr_en`: exactly one pulse per ACKed RX byte, 1 clk after the 8th detected rise.
- `fifo_tx_rd_en`: exactly one pulse per byte load, in the same clk as the detected SCL fall.
- Simultaneous events: a START/STOP event overrides any SCL edge in the same cycle.
- Reset mid-transfer: immediate IDLE, SDA released.

## Structure
- Package `i2c_pkg`: state enum `i2c_slave_state_t`, constants `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1. The package is shared with future I2C blocks.
- Sub-module `i2c_line_sync`: synchronizers plus SCL rise/fall and START/STOP detection. It is reusable by `i2c_master`.
- FSM and shift/counter logic live in `i2c_slave`.

## Test plan
- Write 0xA0 (addr 0x50, W), data 0x3C, 0xC5, STOP → ACK ×3; two `fifo_rx_wr_en` pulses with `rx_data` 0x3C, then 0xC5; `busy` 1 then 0 after STOP.
- Address 0x51 W, then 0x3C → no ACK; `sda_oe` never 1; no strobes; `busy`=0 throughout.
- Read 0xA1, FIFO preloaded 0x96, 0x0F; master ACKs the first byte and NACKs the second → SDA carries 0x96 then 0x0F; two `fifo_tx_rd_en` pulses; → WAIT_STOP, SDA released.
- Read with `tx_empty`=1 → byte 0xFF on SDA, `tx_underrun` pulse, `fifo_tx_rd_en` pulse.
- Write with `rx_full`=1 on the second byte → first byte ACKed and written; second NACKed, no `fifo_rx_wr_en`.
- Repeated START mid-byte, then 0xA1 read; separately, `i2c_reset_n` low mid-ACK → new address phase restarts cleanly; reset releases `sda_oe` asynchronously and returns to IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bit levels and address matching.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRxByte,
        StRxAck,
        StTxByte,
        StTxAck,
        StWaitStop
    } i2c_slave_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // True when the 7-bit address field of an address byte equals addr.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Bus pins and byte-FIFO ports of the I2C target, grouped for connection.
interface i2c_slave_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       fifo_tx_rd_en;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       fifo_rx_wr_en;
    logic       busy;
    logic       slave_rw;
    logic       tx_underrun;

    modport slave (
        input  scl_in, sda_in, tx_data, tx_empty, rx_full,
        output sda_oe, fifo_tx_rd_en, rx_data, fifo_rx_wr_en, busy, slave_rw, tx_underrun
    );

    modport master (
        output scl_in, sda_in, tx_data, tx_empty, rx_full,
        input  sda_oe, fifo_tx_rd_en, rx_data, fifo_rx_wr_en, busy, slave_rw, tx_underrun
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA and reports SCL edges plus START/STOP as registered one-cycle events.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       rise_q, fall_q, start_q, stop_q, sda_q;
    logic       rise_d, fall_d, start_d, stop_d;
    logic       scl_high;

    // Edge and condition detection on the synchronised levels.
    always_comb begin
        scl_high = scl_sync_q[1] & scl_hist_q;
        rise_d   = scl_sync_q[1] & ~scl_hist_q;
        fall_d   = ~scl_sync_q[1] & scl_hist_q;
        start_d  = scl_high & sda_hist_q & ~sda_sync_q[1];
        stop_d   = scl_high & ~sda_hist_q & sda_sync_q[1];
    end

    // Synchroniser, history and event registers; idle bus level after reset avoids false events.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_q      <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            // Delayed with the events so a sample taken on rise_o sees the matching SDA level.
            sda_q      <= sda_sync_q[1];
        end
    end

    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign sda_o      = sda_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: fixed 7-bit address, received bytes to an RX FIFO, transmitted bytes from a TX FIFO.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic           clk,
    input  logic           i2c_reset_n,
    i2c_slave_if.slave     bus
);

    logic scl_rise, scl_fall, start_ev, stop_ev, sda_s;

    i2c_line_sync u_line_sync (
        .clk_i      (clk),
        .rst_ni     (i2c_reset_n),
        .scl_i      (bus.scl_in),
        .sda_i      (bus.sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_ev),
        .stop_o     (stop_ev),
        .sda_o      (sda_s)
    );

    i2c_slave_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_wr_q, rx_wr_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    // AddrAck/RxAck: ack drive already started. TxAck: master ACK seen on the rise.
    logic       flag_q, flag_d;
    logic       ack_bit_q, ack_bit_d;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       load_en;

    assign tx_byte = bus.tx_empty ? 8'hFF : bus.tx_data;
    assign rx_byte = {shift_q, sda_s};
    assign load_en = scl_fall & ~start_ev & ~stop_ev & flag_q &
                     (((state_q == StAddrAck) & rw_q) | (state_q == StTxAck));

    // State and datapath registers.
    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            shift_q   <= 7'd0;
            sda_oe_q  <= 1'b0;
            rx_data_q <= 8'h00;
            rx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            flag_q    <= 1'b0;
            ack_bit_q <= I2C_ACK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            sda_oe_q  <= sda_oe_d;
            rx_data_q <= rx_data_d;
            rx_wr_q   <= rx_wr_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            flag_q    <= flag_d;
            ack_bit_q <= ack_bit_d;
        end
    end

    // Next-state and datapath update; STOP then START take priority over SCL edges.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        rx_data_d = rx_data_q;
        rx_wr_d   = 1'b0;
        busy_d    = busy_q;
        rw_d      = rw_q;
        flag_d    = flag_q;
        ack_bit_d = ack_bit_q;

        if (stop_ev) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_ev) begin
            state_d  = StAddr;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (addr_match(rx_byte, SLAVE_ADDR)) begin
                                rw_d    = sda_s;
                                busy_d  = 1'b1;
                                flag_d  = 1'b0;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StWaitStop;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!flag_q) begin
                            sda_oe_d = 1'b1;
                            flag_d   = 1'b1;
                        end else if (rw_q) begin
                            shift_d  = tx_byte[6:0];
                            sda_oe_d = ~tx_byte[7];
                            cnt_d    = 3'd0;
                            state_d  = StTxByte;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = StRxByte;
                        end
                    end
                end
                StRxByte: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (!bus.rx_full) begin
                                rx_data_d = rx_byte;
                                rx_wr_d   = 1'b1;
                                ack_bit_d = I2C_ACK;
                            end else begin
                                ack_bit_d = I2C_NACK;
                            end
                            flag_d  = 1'b0;
                            state_d = StRxAck;
                        end
                    end
                end
                StRxAck: begin
                    if (scl_fall) begin
                        if (!flag_q) begin
                            sda_oe_d = (ack_bit_q == I2C_ACK);
                            flag_d   = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = StRxByte;
                        end
                    end
                end
                StTxByte: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            flag_d   = 1'b0;
                            state_d  = StTxAck;
                        end else begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b1};
                            cnt_d    = cnt_q + 3'd1;
                        end
                    end
                end
                StTxAck: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state_d = StWaitStop;
                        end else begin
                            flag_d = 1'b1;
                        end
                    end else if (scl_fall && flag_q) begin
                        shift_d  = tx_byte[6:0];
                        sda_oe_d = ~tx_byte[7];
                        cnt_d    = 3'd0;
                        state_d  = StTxByte;
                    end
                end
                StWaitStop: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs: registered pins plus the combinational TX load strobes.
    always_comb begin
        bus.sda_oe        = sda_oe_q;
        bus.rx_data       = rx_data_q;
        bus.fifo_rx_wr_en = rx_wr_q;
        bus.busy          = busy_q;
        bus.slave_rw      = rw_q;
        bus.fifo_tx_rd_en = load_en;
        bus.tx_underrun   = load_en & bus.tx_empty;
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, FIFO models and a strobe-driven scoreboard.
module tb_i2c_slave;

    localparam int Q = 6;
    localparam logic [6:0] ADDR = 7'h50;

    logic clk = 1'b0;
    logic i2c_reset_n;
    logic scl_m, sda_m;
    logic sda_line;

    i2c_slave_if bus ();

    i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk         (clk),
        .i2c_reset_n (i2c_reset_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target.
    assign sda_line   = sda_m & ~bus.sda_oe;
    assign bus.sda_in = sda_line;
    assign bus.scl_in = scl_m;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] txq[$];
    int oe_cnt = 0, busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, und_cnt = 0;

    logic [7:0] wbuf[8];
    logic       wfull[8];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: checks every strobe at negedge, then advances the TX FIFO after the load edge.
    initial begin : monitor
        logic pend;
        logic [7:0] e;
        bus.tx_empty = 1'b1;
        bus.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            pend = 1'b0;
            if (bus.sda_oe === 1'b1) oe_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.tx_underrun === 1'b1) und_cnt++;
            if (bus.fifo_rx_wr_en === 1'b1) begin
                wr_cnt++;
                chk("rx_wr_expected", 32'(rx_exp.size() != 0), 1);
                if (rx_exp.size() != 0) begin
                    e = rx_exp.pop_front();
                    chk("rx_data", 32'(bus.rx_data), 32'(e));
                end
            end
            if (bus.fifo_tx_rd_en === 1'b1) begin
                rd_cnt++;
                chk("tx_underrun", 32'(bus.tx_underrun), 32'(txq.size() == 0));
                pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pend && txq.size() != 0) void'(txq.pop_front());
            bus.tx_empty = (txq.size() == 0);
            bus.tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // START from idle bus or repeated START from SCL low.
    task automatic do_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic do_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic bit_w(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bit_r(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_line; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(b[i]);
        bit_r(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic ack);
        logic bb;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_r(bb);
            b = {b[6:0], bb};
        end
        bit_w(ack);
    endtask

    // Write transaction of n bytes from wbuf; wfull[i] is rx_full while byte i is sent.
    task automatic xfer_write(input logic [6:0] addr, input int n);
        logic match, ack, exp_ack;
        int oe0, busy0, wr0, nwr;
        match = (addr == ADDR);
        oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_cnt; nwr = 0;
        do_start();
        send_byte({addr, 1'b0}, ack);
        chk("addr_ack_w", 32'(ack), 32'(match ? 1'b0 : 1'b1));
        if (match) begin
            chk("busy_addressed", 32'(bus.busy), 1);
            chk("slave_rw_w", 32'(bus.slave_rw), 0);
        end
        for (int i = 0; i < n; i++) begin
            bus.rx_full = wfull[i];
            exp_ack = match && !wfull[i];
            if (exp_ack) begin
                rx_exp.push_back(wbuf[i]);
                nwr++;
            end
            send_byte(wbuf[i], ack);
            chk("data_ack", 32'(ack), 32'(exp_ack ? 1'b0 : 1'b1));
        end
        bus.rx_full = 1'b0;
        do_stop();
        chk("busy_after_stop", 32'(bus.busy), 0);
        chk("rx_wr_count", 32'(wr_cnt - wr0), 32'(nwr));
        chk("rx_drained", 32'(rx_exp.size()), 0);
        if (!match) begin
            chk("no_drive_unaddressed", 32'(oe_cnt - oe0), 0);
            chk("no_busy_unaddressed", 32'(busy_cnt - busy0), 0);
        end
    endtask

    // Read transaction of n bytes; master ACKs all but the last byte.
    task automatic xfer_read(input logic [6:0] addr, input int n);
        logic match, ack;
        logic [7:0] b;
        logic [7:0] exp_b[$];
        int sz, rd0, und0, oe0;
        match = (addr == ADDR);
        sz = txq.size();
        rd0 = rd_cnt; und0 = und_cnt; oe0 = oe_cnt;
        for (int i = 0; i < n; i++) exp_b.push_back(i < sz ? txq[i] : 8'hFF);
        do_start();
        send_byte({addr, 1'b1}, ack);
        chk("addr_ack_r", 32'(ack), 32'(match ? 1'b0 : 1'b1));
        if (match) begin
            chk("slave_rw_r", 32'(bus.slave_rw), 1);
            for (int i = 0; i < n; i++) begin
                recv_byte(b, (i == n - 1) ? 1'b1 : 1'b0);
                chk("rd_byte", 32'(b), 32'(exp_b[i]));
            end
            chk("released_after_nack", 32'(bus.sda_oe), 0);
            chk("busy_wait_stop", 32'(bus.busy), 1);
        end
        do_stop();
        chk("busy_after_stop_r", 32'(bus.busy), 0);
        chk("tx_rd_count", 32'(rd_cnt - rd0), 32'(match ? n : 0));
        chk("tx_underrun_count", 32'(und_cnt - und0), 32'((match && n > sz) ? n - sz : 0));
        chk("rx_drained_r", 32'(rx_exp.size()), 0);
        if (!match) chk("no_drive_unaddressed_r", 32'(oe_cnt - oe0), 0);
    endtask

    initial begin : stim
        logic ack;
        int kind, n, pre;
        logic [6:0] a;

        i2c_reset_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        bus.rx_full = 1'b0;
        wait_clk(4);
        chk("reset_sda_oe", 32'(bus.sda_oe), 0);
        chk("reset_rx_wr", 32'(bus.fifo_rx_wr_en), 0);
        chk("reset_tx_rd", 32'(bus.fifo_tx_rd_en), 0);
        chk("reset_rx_data", 32'(bus.rx_data), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_rw", 32'(bus.slave_rw), 0);
        chk("reset_underrun", 32'(bus.tx_underrun), 0);
        i2c_reset_n = 1'b1;
        wait_clk(8);

        // Addressed write of two bytes.
        wbuf[0] = 8'h3C; wbuf[1] = 8'hC5; wfull[0] = 1'b0; wfull[1] = 1'b0;
        xfer_write(7'h50, 2);

        // Wrong address: no ACK, no drive, no strobes.
        wbuf[0] = 8'h3C; wfull[0] = 1'b0;
        xfer_write(7'h51, 1);

        // Read two preloaded bytes.
        txq.push_back(8'h96);
        txq.push_back(8'h0F);
        wait_clk(3);
        xfer_read(7'h50, 2);

        // Read from an empty TX FIFO.
        xfer_read(7'h50, 1);

        // RX sink full on the second byte.
        wbuf[0] = 8'h5A; wbuf[1] = 8'hA5; wfull[0] = 1'b0; wfull[1] = 1'b1;
        xfer_write(7'h50, 2);

        // Repeated START in the middle of a byte, then a read.
        do_start();
        send_byte({ADDR, 1'b0}, ack);
        chk("rs_addr_ack", 32'(ack), 0);
        bus.rx_full = 1'b0;
        rx_exp.push_back(8'h77);
        send_byte(8'h77, ack);
        chk("rs_data_ack", 32'(ack), 0);
        bit_w(1'b1); bit_w(1'b0); bit_w(1'b0);
        txq.push_back(8'hE1);
        wait_clk(2);
        xfer_read(7'h50, 1);

        // Reset asserted while the target drives the address ACK.
        do_start();
        for (int i = 7; i >= 0; i--) bit_w(i == 7 || i == 5);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        chk("ack_driven_before_reset", 32'(bus.sda_oe), 1);
        chk("busy_before_reset", 32'(bus.busy), 1);
        #3;
        i2c_reset_n = 1'b0;
        #1;
        chk("reset_releases_sda", 32'(bus.sda_oe), 0);
        chk("reset_clears_busy", 32'(bus.busy), 0);
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
        i2c_reset_n = 1'b1;
        wait_clk(Q);
        wbuf[0] = 8'h81; wbuf[1] = 8'h18; wfull[0] = 1'b0; wfull[1] = 1'b0;
        xfer_write(7'h50, 2);

        // Randomised mix of reads and writes against the reference model.
        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
            n = $urandom_range(1, 3);
            if (kind == 0) begin
                for (int i = 0; i < n; i++) begin
                    wbuf[i]  = 8'($urandom);
                    wfull[i] = ($urandom_range(0, 3) == 0);
                end
                xfer_write(a, n);
            end else begin
                pre = $urandom_range(0, 3);
                for (int i = 0; i < pre; i++) txq.push_back(8'($urandom));
                wait_clk(3);
                xfer_read(a, n);
            end
        end

        wait_clk(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
